// File: rtl/cmd_pkg.sv
// Shared opcodes, response status codes and controller state encoding for cmd_executor.
package cmd_pkg;

   localparam logic [7:0] OP_NOP      = 8'h00;
   localparam logic [7:0] OP_SET_ADDR = 8'h10;
   localparam logic [7:0] OP_WRITE    = 8'h20;
   localparam logic [7:0] OP_READ     = 8'h30;

   localparam logic [7:0] ST_OK       = 8'h00;
   localparam logic [7:0] ST_BAD_OP   = 8'hE1;
   localparam logic [7:0] ST_BAD_CRC  = 8'hE2;
   localparam logic [7:0] ST_TIMEOUT  = 8'hE3;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      EXEC,
      MEM_WAIT,
      TX_STATUS,
      TX_WAIT_S,
      TX_DATA,
      TX_WAIT_D
   } state_t;

endpackage

// File: rtl/crc8_calc.sv
// Combinational CRC-8 (poly 0x07, init 0x00, MSB first) over a 24-bit frame body.
module crc8_calc (
   input  logic [23:0] data,
   output logic [7:0]  crc
);

   always_comb begin
      crc = 8'h00;
      for (int i = 23; i >= 0; i--) begin
         if (crc[7] ^ data[i]) crc = {crc[6:0], 1'b0} ^ 8'h07;
         else                  crc = {crc[6:0], 1'b0};
      end
   end

endmodule

// File: rtl/cmd_executor.sv
// Frame-driven memory command executor answering every frame with a status byte then a data byte.
// Define CMD_EXECUTOR_CRC_CHECK_EN to reject frames whose CRC-8 does not match.
module cmd_executor
   import cmd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        frame_done,
   input  logic [7:0]  cmd,
   input  logic [7:0]  arg1,
   input  logic [7:0]  arg2,
   input  logic [7:0]  crc,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_we,
   output logic        mem_re,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ack,
   output logic [7:0]  tx_byte,
   output logic        tx_start,
   input  logic        tx_done,
   output logic        busy,
   output logic        overrun
);

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic        frame_seen_q, frame_seen_d;
   logic [7:0]  cmd_q, cmd_d, arg1_q, arg1_d, arg2_q, arg2_d, crc_q, crc_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        we_q, we_d, re_q, re_d;
   logic [7:0]  timer_q, timer_d;
   logic [7:0]  status_q, status_d, data_q, data_d;
   logic [7:0]  tx_byte_q, tx_byte_d;
   logic        tx_start_q, tx_start_d;
   logic        overrun_q, overrun_d;
   logic        frame_new;
   logic        crc_ok;

`ifdef CMD_EXECUTOR_CRC_CHECK_EN
   logic [7:0] crc_calc;

   crc8_calc u_crc8_calc (
      .data ({cmd_q, arg1_q, arg2_q}),
      .crc  (crc_calc)
   );

   assign crc_ok = (crc_calc == crc_q);
`else
   logic crc_unused;

   assign crc_unused = ^crc_q;
   assign crc_ok     = 1'b1;
`endif

   assign frame_new = (frame_done != frame_seen_q);

   always_comb begin
      state_d      = state_q;
      frame_seen_d = frame_seen_q;
      cmd_d        = cmd_q;
      arg1_d       = arg1_q;
      arg2_d       = arg2_q;
      crc_d        = crc_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      we_d         = we_q;
      re_d         = re_q;
      timer_d      = timer_q;
      status_d     = status_q;
      data_d       = data_q;
      tx_byte_d    = tx_byte_q;
      tx_start_d   = tx_start_q;
      overrun_d    = overrun_q;

      // Every frame edge is consumed; only one seen in IDLE with en high is executed.
      if (frame_new) begin
         frame_seen_d = frame_done;
         if (state_q != IDLE) overrun_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (frame_new && en) begin
               cmd_d   = cmd;
               arg1_d  = arg1;
               arg2_d  = arg2;
               crc_d   = crc;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (crc_ok) begin
               state_d = EXEC;
            end else begin
               status_d = ST_BAD_CRC;
               data_d   = 8'h00;
               state_d  = TX_STATUS;
            end
         end
         EXEC: begin
            status_d = ST_OK;
            data_d   = 8'h00;
            state_d  = TX_STATUS;
            case (cmd_q)
               OP_NOP: ;
               OP_SET_ADDR: addr_d = {arg1_q, arg2_q};
               OP_WRITE: begin
                  wdata_d = arg1_q;
                  we_d    = 1'b1;
                  timer_d = 8'h00;
                  state_d = MEM_WAIT;
               end
               OP_READ: begin
                  re_d    = 1'b1;
                  timer_d = 8'h00;
                  state_d = MEM_WAIT;
               end
               default: status_d = ST_BAD_OP;
            endcase
         end
         // An ack arriving on the expiry cycle still wins over the timeout.
         MEM_WAIT: begin
            if (mem_ack) begin
               we_d     = 1'b0;
               re_d     = 1'b0;
               addr_d   = addr_q + 16'd1;
               status_d = ST_OK;
               data_d   = re_q ? mem_rdata : 8'h00;
               state_d  = TX_STATUS;
            end else if (timer_q == TIMEOUT_LAST) begin
               we_d     = 1'b0;
               re_d     = 1'b0;
               status_d = ST_TIMEOUT;
               data_d   = 8'h00;
               state_d  = TX_STATUS;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         TX_STATUS: begin
            tx_byte_d  = status_q;
            tx_start_d = ~tx_start_q;
            state_d    = TX_WAIT_S;
         end
         TX_WAIT_S: begin
            if (tx_done == tx_start_q) state_d = TX_DATA;
         end
         TX_DATA: begin
            tx_byte_d  = data_q;
            tx_start_d = ~tx_start_q;
            state_d    = TX_WAIT_D;
         end
         TX_WAIT_D: begin
            if (tx_done == tx_start_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset re-aligns both toggle handshakes so no phantom frame or byte appears.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         frame_seen_q <= frame_done;
         cmd_q        <= 8'h00;
         arg1_q       <= 8'h00;
         arg2_q       <= 8'h00;
         crc_q        <= 8'h00;
         addr_q       <= 16'h0000;
         wdata_q      <= 8'h00;
         we_q         <= 1'b0;
         re_q         <= 1'b0;
         timer_q      <= 8'h00;
         status_q     <= 8'h00;
         data_q       <= 8'h00;
         tx_byte_q    <= 8'h00;
         tx_start_q   <= tx_done;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         frame_seen_q <= frame_seen_d;
         cmd_q        <= cmd_d;
         arg1_q       <= arg1_d;
         arg2_q       <= arg2_d;
         crc_q        <= crc_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         we_q         <= we_d;
         re_q         <= re_d;
         timer_q      <= timer_d;
         status_q     <= status_d;
         data_q       <= data_d;
         tx_byte_q    <= tx_byte_d;
         tx_start_q   <= tx_start_d;
         overrun_q    <= overrun_d;
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_we    = we_q;
   assign mem_re    = re_q;
   assign tx_byte   = tx_byte_q;
   assign tx_start  = tx_start_q;
   assign busy      = (state_q != IDLE);
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_cmd_executor.sv
// Scoreboard bench for cmd_executor: directed frames, memory and byte-transmitter models.
module tb_cmd_executor;
   import cmd_pkg::*;

   localparam int TIMEOUT = 4;

   logic        clk        = 1'b0;
   logic        reset      = 1'b1;
   logic        en         = 1'b0;
   logic        frame_done = 1'b0;
   logic [7:0]  cmd        = 8'h00;
   logic [7:0]  arg1       = 8'h00;
   logic [7:0]  arg2       = 8'h00;
   logic [7:0]  crc        = 8'h00;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [7:0]  mem_rdata  = 8'h00;
   logic        mem_ack    = 1'b0;
   logic [7:0]  tx_byte;
   logic        tx_start;
   logic        tx_done    = 1'b0;
   logic        busy;
   logic        overrun;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  exp_q[$];
   int          tx_count   = 0;
   logic        tx_last    = 1'b0;
   logic        tx_pending = 1'b0;
   int          tx_wait    = 0;

   logic        exp_mem_valid  = 1'b0;
   logic        exp_mem_we     = 1'b0;
   logic [15:0] exp_mem_addr   = 16'h0000;
   logic [7:0]  exp_mem_wdata  = 8'h00;
   int          ack_delay      = 0;
   logic [7:0]  rd_value       = 8'h00;
   int          exp_strobe_len = 0;
   logic        mem_active     = 1'b0;
   int          mem_len        = 0;
   logic [15:0] exp_addr       = 16'h0000;

   cmd_executor #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .frame_done (frame_done),
      .cmd        (cmd),
      .arg1       (arg1),
      .arg2       (arg2),
      .crc        (crc),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_re     (mem_re),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .tx_byte    (tx_byte),
      .tx_start   (tx_start),
      .tx_done    (tx_done),
      .busy       (busy),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] crc8Ref(input logic [23:0] bits);
      logic [7:0] r = 8'h00;
      for (int i = 23; i >= 0; i--) begin
         logic fb = r[7] ^ bits[i];
         r = {r[6:0], 1'b0};
         if (fb) r = r ^ 8'h07;
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic failCheck(input string name, input string detail);
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s: %s", name, detail);
   endtask

   // Byte transmitter: checks each requested byte, then acknowledges a few cycles later.
   always @(negedge clk) begin
      if (reset) begin
         tx_last    = tx_start;
         tx_pending = 1'b0;
      end else if (tx_start !== tx_last) begin
         tx_last = tx_start;
         tx_count++;
         if (exp_q.size() == 0)
            failCheck("unexpected_tx", $sformatf("got tx_byte 0x%0h, required no byte", tx_byte));
         else
            checkOutput("tx_byte", 32'(tx_byte), 32'(exp_q.pop_front()));
         tx_pending = 1'b1;
         tx_wait    = 2;
      end else if (tx_pending) begin
         if (tx_wait == 0) begin
            tx_done    = tx_start;
            tx_pending = 1'b0;
         end else begin
            tx_wait--;
         end
      end
   end

   // Memory: checks the access on the first strobe cycle, acks after ack_delay cycles (0 = never).
   always @(negedge clk) begin
      if (reset || !(mem_we || mem_re)) begin
         if (mem_active && !reset && exp_strobe_len != 0)
            checkOutput("strobe_len", 32'(mem_len), 32'(exp_strobe_len));
         mem_active = 1'b0;
         mem_len    = 0;
         mem_ack    = 1'b0;
      end else begin
         if (!mem_active) begin
            mem_active = 1'b1;
            if (!exp_mem_valid) begin
               failCheck("unexpected_strobe", $sformatf("got strobe at 0x%0h, required none", mem_addr));
            end else begin
               checkOutput("mem_addr", 32'(mem_addr), 32'(exp_mem_addr));
               checkOutput("mem_we", 32'(mem_we), 32'(exp_mem_we));
               checkOutput("mem_re", 32'(mem_re), 32'(!exp_mem_we));
               if (exp_mem_we) checkOutput("mem_wdata", 32'(mem_wdata), 32'(exp_mem_wdata));
               exp_mem_valid = 1'b0;
            end
         end
         mem_len++;
         if (ack_delay != 0 && mem_len == ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = rd_value;
         end else begin
            mem_ack = 1'b0;
         end
      end
   end

   task automatic expectMem(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                            input int delay, input logic [7:0] rdata, input int len);
      exp_mem_valid  = 1'b1;
      exp_mem_we     = we;
      exp_mem_addr   = addr;
      exp_mem_wdata  = wdata;
      ack_delay      = delay;
      rd_value       = rdata;
      exp_strobe_len = len;
   endtask

   task automatic applyStimulus(input logic [7:0] c, input logic [7:0] a1, input logic [7:0] a2,
                                input logic bad_crc, input logic [7:0] exp_status,
                                input logic [7:0] exp_data, input logic expect_resp);
      logic [7:0] good;
      @(negedge clk);
      good = crc8Ref({c, a1, a2});
      cmd  = c;
      arg1 = a1;
      arg2 = a2;
      crc  = bad_crc ? ~good : good;
      if (expect_resp) begin
         exp_q.push_back(exp_status);
         exp_q.push_back(exp_data);
      end
      frame_done = ~frame_done;
   endtask

   task automatic waitIdle(input string name);
      int cyc = 0;
      @(negedge clk);
      while ((busy || exp_q.size() != 0 || tx_pending) && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 300) failCheck(name, "timed out after 300 cycles, required return to idle");
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int cyc;
      int tx_before;

      repeat (3) @(negedge clk);
      checkOutput("reset_busy", 32'(busy), 32'h0);
      checkOutput("reset_mem_addr", 32'(mem_addr), 32'h0);
      checkOutput("reset_mem_we", 32'(mem_we), 32'h0);
      checkOutput("reset_mem_re", 32'(mem_re), 32'h0);
      checkOutput("reset_mem_wdata", 32'(mem_wdata), 32'h0);
      checkOutput("reset_tx_byte", 32'(tx_byte), 32'h0);
      checkOutput("reset_tx_start", 32'(tx_start), 32'h0);
      checkOutput("reset_overrun", 32'(overrun), 32'h0);
      reset = 1'b0;
      en    = 1'b1;

      applyStimulus(OP_NOP, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
      waitIdle("wait_nop");
      checkOutput("addr_after_nop", 32'(mem_addr), 32'h0000);

      applyStimulus(OP_SET_ADDR, 8'h12, 8'h34, 1'b0, 8'h00, 8'h00, 1'b1);
      waitIdle("wait_set_1234");
      checkOutput("addr_set_1234", 32'(mem_addr), 32'h1234);

      expectMem(1'b0, 16'h1234, 8'h00, 3, 8'hA5, 3);
      applyStimulus(OP_READ, 8'h00, 8'h00, 1'b0, 8'h00, 8'hA5, 1'b1);
      waitIdle("wait_read_1234");
      checkOutput("addr_after_read", 32'(mem_addr), 32'h1235);

      applyStimulus(OP_SET_ADDR, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b1);
      waitIdle("wait_set_ffff");
      checkOutput("addr_set_ffff", 32'(mem_addr), 32'hFFFF);

      expectMem(1'b1, 16'hFFFF, 8'h5A, 1, 8'h00, 1);
      applyStimulus(OP_WRITE, 8'h5A, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
      waitIdle("wait_write_ffff");
      checkOutput("addr_wrap", 32'(mem_addr), 32'h0000);

      expectMem(1'b0, 16'h0000, 8'h00, 0, 8'h00, TIMEOUT);
      applyStimulus(OP_READ, 8'h00, 8'h00, 1'b0, ST_TIMEOUT, 8'h00, 1'b1);
      waitIdle("wait_read_timeout");
      checkOutput("addr_after_timeout", 32'(mem_addr), 32'h0000);
      checkOutput("timeout_strobe_seen", 32'(exp_mem_valid), 32'h0);

      expectMem(1'b0, 16'h0000, 8'h00, TIMEOUT, 8'h3C, TIMEOUT);
      applyStimulus(OP_READ, 8'h00, 8'h00, 1'b0, 8'h00, 8'h3C, 1'b1);
      waitIdle("wait_read_ack_at_expiry");
      checkOutput("addr_ack_at_expiry", 32'(mem_addr), 32'h0001);

      applyStimulus(8'h7F, 8'h00, 8'h00, 1'b0, ST_BAD_OP, 8'h00, 1'b1);
      waitIdle("wait_bad_opcode");
      checkOutput("addr_after_bad_op", 32'(mem_addr), 32'h0001);

`ifdef CMD_EXECUTOR_CRC_CHECK_EN
      applyStimulus(OP_WRITE, 8'h77, 8'h00, 1'b1, ST_BAD_CRC, 8'h00, 1'b1);
      exp_addr = 16'h0001;
`else
      expectMem(1'b1, 16'h0001, 8'h77, 2, 8'h00, 2);
      applyStimulus(OP_WRITE, 8'h77, 8'h00, 1'b1, 8'h00, 8'h00, 1'b1);
      exp_addr = 16'h0002;
`endif
      waitIdle("wait_bad_crc_frame");
      checkOutput("addr_after_crc_frame", 32'(mem_addr), 32'(exp_addr));
      checkOutput("crc_frame_strobe_state", 32'(exp_mem_valid), 32'h0);

      en = 1'b0;
      @(negedge clk);
      frame_done = ~frame_done;
      repeat (3) @(negedge clk);
      en = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("busy_stale_frame", 32'(busy), 32'h0);
      checkOutput("overrun_stale_frame", 32'(overrun), 32'h0);

      tx_before = tx_count;
      applyStimulus(OP_NOP, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
      cyc = 0;
      while (tx_start === tx_done && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 100) failCheck("wait_first_tx", "timed out, required a status byte request");
      frame_done = ~frame_done;
      waitIdle("wait_overrun");
      repeat (10) @(negedge clk);
      checkOutput("overrun_set", 32'(overrun), 32'h1);
      checkOutput("overrun_busy", 32'(busy), 32'h0);
      checkOutput("overrun_tx_bytes", 32'(tx_count - tx_before), 32'd2);

      tx_before = tx_count;
      expectMem(1'b0, exp_addr, 8'h00, 0, 8'h00, 0);
      applyStimulus(OP_READ, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
      cyc = 0;
      while (!mem_re && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 20) failCheck("wait_read_strobe", "timed out, required mem_re high");
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("midreset_mem_re", 32'(mem_re), 32'h0);
      checkOutput("midreset_mem_we", 32'(mem_we), 32'h0);
      checkOutput("midreset_busy", 32'(busy), 32'h0);
      checkOutput("midreset_overrun", 32'(overrun), 32'h0);
      checkOutput("midreset_mem_addr", 32'(mem_addr), 32'h0000);
      @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      checkOutput("midreset_tx_bytes", 32'(tx_count - tx_before), 32'd0);
      checkOutput("midreset_idle", 32'(busy), 32'h0);
      checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
